// File: rtl/tdm_mux.sv
// tdm_mux: parallel-to-serial time-division multiplexer.
// Captures an N-bit channel word and emits one channel bit per accepted beat,
// in index order 0..N-1, with the channel index on sel and frame markers.
module tdm_mux #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         inpt,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out,
  output logic [$clog2(N)-1:0] sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic [7:0]           frame_count
);

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] last_sel = SW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t       state;
  logic [N-1:0] shadow;
  logic         last_beat;
  logic         transfer;

  // Beat handshake decode; the last beat is the only point a new word may
  // enter while a frame is in flight.
  assign last_beat = (state == SEND) && (sel == last_sel);
  assign transfer  = (state == SEND) && out_ready;

  // Ready is combinational from out_ready so back-to-back frames need no bubble.
  assign in_ready = !rst && ((state == IDLE) || (last_beat && out_ready));

  // Outputs decoded from registered state only (frame markers are pure decodes).
  assign out_valid   = (state == SEND);
  assign out         = out_valid & shadow[sel];
  assign frame_start = out_valid && (sel == '0);
  assign frame_end   = last_beat;

  // Frame sequencer: word capture, channel counter and completed-frame count.
  // NOTE: every register here uses non-blocking assignment so all updates
  // see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: shadow is an ordinary register, not a memory, so it is cleared
      // on reset to keep out at 0 and avoid leaking a stale word.
      state       <= IDLE;
      sel         <= '0;
      shadow      <= '0;
      frame_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shadow <= inpt;
            sel    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (transfer) begin
            if (sel == last_sel) begin
              frame_count <= frame_count + 8'd1;
              sel         <= '0;
              if (in_valid) begin
                shadow <= inpt;
              end else begin
                state <= IDLE;
              end
            end else begin
              sel <= sel + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// Self-checking bench for tdm_mux (N=16): a scoreboard queue holds the
// expected beats of every accepted word; a negedge monitor compares them
// against the serial output, alongside directed checks for each scenario.
module tb_tdm_mux;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  inpt;
  logic          in_valid;
  logic          in_ready;
  logic          out;
  logic [3:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic          frame_start;
  logic          frame_end;
  logic [7:0]    frame_count;

  typedef struct {
    logic [3:0] sel;
    logic       bit_val;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] exp_fc = 8'd0;
  bit         mon_en = 1'b0;
  int         tests  = 0;
  int         fails  = 0;

  tdm_mux #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .inpt        (inpt),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out         (out),
    .sel         (sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares state against the expected beat queue and
  // pushes/pops on the handshakes that will occur at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      automatic int    n = sb.size();
      automatic beat_t e;
      check("sb_out_valid", out_valid, n != 0);
      check("sb_in_ready", in_ready, !rst && (n == 0 || (n == 1 && out_ready)));
      check("sb_frame_count", frame_count, exp_fc);
      if (n != 0) begin
        e = sb[0];
        check("sb_sel", sel, e.sel);
        check("sb_out", out, e.bit_val);
        check("sb_frame_start", frame_start, e.sel == 4'd0);
        check("sb_frame_end", frame_end, e.sel == 4'd15);
      end else begin
        check("sb_idle_fs", frame_start, 0);
        check("sb_idle_fe", frame_end, 0);
      end
      if (out_valid && out_ready) begin
        check("sb_depth", n != 0, 1);
        if (n != 0) begin
          void'(sb.pop_front());
          if (n == 1 && !rst) exp_fc = exp_fc + 8'd1;
        end
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < N; i++) begin
          e.sel     = 4'(i);
          e.bit_val = inpt[i];
          sb.push_back(e);
        end
      end
      if (rst) begin
        sb.delete();
        exp_fc = 8'd0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until accepted (bounded), then drop in_valid.
  task automatic send_word(input logic [N-1:0] w);
    bit ok = 1'b0;
    inpt     = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_wait", ok, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_wait", ok, 1);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] w;
    logic [N-1:0] rec;
    int           nb;
    int           es;

    rst       = 1'b1;
    in_valid  = 1'b1;
    inpt      = 16'hBEEF;
    out_ready = 1'b1;

    // Reset held two cycles with in_valid high.
    step();
    mon_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_sel", sel, 0);
      check("rst_fc", frame_count, 0);
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_release_ready", in_ready, 1);
    step();

    // Single frame 16'hA5C3.
    w = 16'hA5C3;
    send_word(w);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("sf_sel", sel, k);
      check("sf_out", out, w[k]);
      check("sf_start", frame_start, k == 0);
      check("sf_end", frame_end, k == 15);
      step();
    end
    @(negedge clk);
    check("sf_idle", out_valid, 0);
    check("sf_fc", frame_count, 1);
    step();

    // Back-to-back frames 16'hFFFF then 16'h0001.
    inpt     = 16'hFFFF;
    in_valid = 1'b1;
    @(negedge clk);
    check("b2b_ready_idle", in_ready, 1);
    step();
    inpt = 16'h0001;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
      check("b2b_sel", sel, c % 16);
      check("b2b_out", out, (c < 16) ? 1 : (c == 16));
      check("b2b_ready", in_ready, (c == 15) || (c == 31));
      step();
      if (c == 15) in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle", out_valid, 0);
    check("b2b_fc", frame_count, 3);
    step();

    // Backpressure: 16'h8000 with out_ready low in frame cycles 3..7.
    send_word(16'h8000);
    for (int c = 0; c < 21; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      es = (c < 3) ? c : ((c <= 7) ? 3 : c - 5);
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_sel", sel, es);
      check("bp_out", out, es == 15);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_done", out_valid, 0);
    check("bp_fc", frame_count, 4);
    step();

    // Reset asserted during the sel == 7 beat.
    send_word(16'h5A5A);
    repeat (7) step();
    rst = 1'b1;
    @(negedge clk);
    check("mr_sel_before", sel, 7);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mr_valid", out_valid, 0);
    check("mr_sel", sel, 0);
    check("mr_out", out, 0);
    check("mr_fc", frame_count, 0);
    step();
    send_word(16'h0003);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mr_new_sel", sel, k);
      check("mr_new_out", out, k < 2);
      step();
    end
    wait_idle();

    // Loopback through a 1x16 DeMUX, 257 random frames; count wraps to 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int f = 0; f < 257; f++) begin
      w   = N'($urandom);
      rec = '0;
      nb  = 0;
      send_word(w);
      for (int i = 0; i < 400 && nb < N; i++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (out_valid && out_ready) begin
          rec[sel] = out;
          nb++;
        end
        step();
      end
      out_ready = 1'b1;
      check("loop_beats", nb, N);
      check("loop_word", rec, w);
    end
    @(negedge clk);
    check("loop_fc_wrap", frame_count, 1);
    check("sb_empty", sb.size(), 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
